// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencer: prescaled run/pause/idle counter with a show-ahead lap FIFO.
// Commands are single-cycle pulses sampled on posedge clk; all outputs are registered state.
module stopwatch_lap_ctrl #(
   parameter int WIDTH = 4,
   parameter int DIV   = 2,
   parameter int LAPS  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             clear,
   input  logic             lap,
   input  logic             lap_rd,
   output logic [WIDTH-1:0] count,
   output logic             running,
   output logic             tick,
   output logic [WIDTH-1:0] lap_data,
   output logic             lap_valid,
   output logic             lap_full,
   output logic             lap_drop,
   output logic             wrapped
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW = $clog2(LAPS);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [AW:0]   OCC_MAX = (AW + 1)'(LAPS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick_q, tick_d;
   logic             wrapped_q, wrapped_d;
   logic             drop_q, drop_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic [WIDTH-1:0] mem_q [LAPS];

   logic lap_req, push, pop;

   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      count_d   = count_q;
      tick_d    = 1'b0;
      wrapped_d = wrapped_q;
      drop_d    = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;

      lap_req = lap && !clear && ((state_q == S_RUN) || (state_q == S_PAUSE));
      pop     = lap_rd && (occ_q != '0) && !clear;
      // A full FIFO still accepts a lap when a pop frees the head in the same cycle.
      push    = lap_req && ((occ_q != OCC_MAX) || pop);

      if (clear) begin
         state_d   = S_IDLE;
         pre_d     = '0;
         count_d   = '0;
         wrapped_d = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         occ_d     = '0;
      end else begin
         case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN: begin
               if (stop) state_d = S_PAUSE;
               // A due increment is suppressed by stop; the prescaler then holds at its last value.
               if (pre_q == PRE_MAX) begin
                  if (!stop) begin
                     pre_d   = '0;
                     count_d = count_q + WIDTH'(1);
                     tick_d  = 1'b1;
                     if (&count_q) wrapped_d = 1'b1;
                  end
               end else begin
                  pre_d = pre_q + PW'(1);
               end
            end
            S_PAUSE: if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
         endcase

         drop_d = lap_req && !push;
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         occ_d = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         count_q   <= '0;
         tick_q    <= 1'b0;
         wrapped_q <= 1'b0;
         drop_q    <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         wrapped_q <= wrapped_d;
         drop_q    <= drop_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
      end
   end

   // Lap storage needs no reset: reads are masked to 0 while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= count_q;
   end

   assign count     = count_q;
   assign running   = (state_q == S_RUN);
   assign tick      = tick_q;
   assign lap_valid = (occ_q != '0);
   assign lap_full  = (occ_q == OCC_MAX);
   assign lap_drop  = drop_q;
   assign wrapped   = wrapped_q;
   assign lap_data  = lap_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Scoreboard bench for stopwatch_lap_ctrl: expected tick counts and lap pops are queued by the
// stimulus; a negedge monitor consumes them whenever the DUT ticks or a lap pop is accepted.
module tb_stopwatch_lap_ctrl;

   logic       clk = 1'b0;
   logic       rst, start, stop, clear, lap, lap_rd;
   logic [3:0] count, lap_data;
   logic       running, tick, lap_valid, lap_full, lap_drop, wrapped;

   int errors = 0;
   int checks = 0;
   int tick_exp[$];
   int lap_exp[$];

   always #5 clk = ~clk;

   stopwatch_lap_ctrl #(.WIDTH(4), .DIV(2), .LAPS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .lap_rd(lap_rd), .count(count), .running(running), .tick(tick), .lap_data(lap_data),
      .lap_valid(lap_valid), .lap_full(lap_full), .lap_drop(lap_drop), .wrapped(wrapped)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_ticks(input int first, input int n);
      for (int i = 0; i < n; i++) tick_exp.push_back((first + i) % 16);
   endtask

   // Monitor: every tick and every accepted pop must match the head of its queue.
   always @(negedge clk) begin
      if (tick) begin
         if (tick_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tick_unexpected: tick with count=%0d, none expected (t=%0t)", count, $time);
         end else begin
            chk("tick_count", int'(count), tick_exp.pop_front());
         end
      end
      if (lap_rd && lap_valid) begin
         if (lap_exp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL lap_unexpected: popped %0d, none expected (t=%0t)", lap_data, $time);
         end else begin
            chk("lap_pop_data", int'(lap_data), lap_exp.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0; lap_rd = 1'b0;
      cyc(2);
      chk("reset_outputs", int'({count, running, tick, lap_data, lap_valid, lap_full, lap_drop, wrapped}), 0);
      rst = 1'b0;
      cyc(1);

      // Start, then count steps every 2 cycles.
      start = 1'b1; cyc(1); start = 1'b0;
      chk("run_after_start", int'(running), 1);
      chk("count_at_start", int'(count), 0);
      push_ticks(1, 3);
      cyc(1);
      chk("no_tick_first_cycle", int'(tick), 0);
      cyc(1);
      chk("first_tick", int'(tick), 1);
      chk("first_count", int'(count), 1);
      cyc(4);
      chk("count_3", int'(count), 3);

      // Wrap 15 -> 0 at 32 cycles after start.
      push_ticks(4, 12);
      cyc(24);
      chk("count_15", int'(count), 15);
      chk("wrapped_before", int'(wrapped), 0);
      push_ticks(0, 1);
      cyc(2);
      chk("count_wrap0", int'(count), 0);
      chk("wrapped_set", int'(wrapped), 1);
      clear = 1'b1; cyc(1); clear = 1'b0;
      chk("clear_count", int'(count), 0);
      chk("clear_wrapped", int'(wrapped), 0);
      chk("clear_running", int'(running), 0);
      cyc(3);

      // Pause at 5, resume: next tick one cycle after the start edge.
      start = 1'b1; cyc(1); start = 1'b0;
      push_ticks(1, 5);
      cyc(10);
      chk("count_5", int'(count), 5);
      cyc(1);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("paused_running", int'(running), 0);
      chk("paused_count", int'(count), 5);
      cyc(10);
      chk("paused_hold", int'(count), 5);
      start = 1'b1; cyc(1); start = 1'b0;
      chk("resume_running", int'(running), 1);
      chk("resume_no_tick", int'(tick), 0);
      push_ticks(6, 1);
      cyc(1);
      chk("resume_tick", int'(tick), 1);
      chk("resume_count", int'(count), 6);
      clear = 1'b1; cyc(1); clear = 1'b0;

      // Laps at 2,4,6,8 fill the FIFO; the lap at 10 is dropped.
      start = 1'b1; cyc(1); start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         push_ticks(2 * k - 1, 2);
         cyc((k == 1) ? 4 : 3);
         chk("lap_count", int'(count), 2 * k);
         lap = 1'b1; cyc(1); lap = 1'b0;
         if (k <= 4) lap_exp.push_back(2 * k);
         if (k == 1) chk("lap_head_show_ahead", int'(lap_data), 2);
         if (k == 4) begin
            chk("full_after_4", int'(lap_full), 1);
            chk("no_drop_at_4", int'(lap_drop), 0);
         end
      end
      chk("drop_pulse", int'(lap_drop), 1);
      chk("full_after_drop", int'(lap_full), 1);
      stop = 1'b1; cyc(1); stop = 1'b0;
      chk("drop_cleared", int'(lap_drop), 0);
      chk("stop_on_due", int'(count), 10);

      // Full FIFO: simultaneous lap and pop keeps it full, no drop.
      lap = 1'b1; lap_rd = 1'b1;
      lap_exp.push_back(10);
      cyc(1);
      lap = 1'b0; lap_rd = 1'b0;
      chk("full_swap_full", int'(lap_full), 1);
      chk("full_swap_nodrop", int'(lap_drop), 0);
      chk("full_swap_head", int'(lap_data), 4);
      lap_rd = 1'b1; cyc(4); lap_rd = 1'b0;
      chk("drained_valid", int'(lap_valid), 0);
      chk("drained_data", int'(lap_data), 0);
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      chk("pop_empty_noop", int'(lap_valid), 0);

      // Empty FIFO: simultaneous lap and pop only pushes.
      lap = 1'b1; lap_rd = 1'b1;
      lap_exp.push_back(10);
      cyc(1);
      lap = 1'b0; lap_rd = 1'b0;
      chk("empty_swap_valid", int'(lap_valid), 1);
      chk("empty_swap_data", int'(lap_data), 10);
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
      chk("empty_swap_drained", int'(lap_valid), 0);

      // clear + lap + start in RUN wins: IDLE, zero, empty.
      lap = 1'b1; cyc(1); lap = 1'b0;
      chk("lap_in_pause", int'(lap_valid), 1);
      start = 1'b1; cyc(1); start = 1'b0;
      push_ticks(11, 1);
      cyc(1);
      chk("count_11", int'(count), 11);
      clear = 1'b1; lap = 1'b1; start = 1'b1;
      cyc(1);
      clear = 1'b0; lap = 1'b0; start = 1'b0;
      chk("clr_lap_start_outputs", int'({count, running, tick, lap_data, lap_valid, lap_full, lap_drop, wrapped}), 0);
      cyc(2);
      chk("idle_hold_count", int'(count), 0);
      lap = 1'b1; cyc(1); lap = 1'b0;
      chk("lap_in_idle_ignored", int'(lap_valid), 0);

      // rst mid-run discards the count and in-flight laps.
      start = 1'b1; cyc(1); start = 1'b0;
      push_ticks(1, 2);
      cyc(4);
      chk("pre_rst_count", int'(count), 2);
      lap = 1'b1; cyc(1); lap = 1'b0;
      chk("pre_rst_valid", int'(lap_valid), 1);
      rst = 1'b1; cyc(1);
      chk("rst_midrun_outputs", int'({count, running, tick, lap_data, lap_valid, lap_full, lap_drop, wrapped}), 0);
      rst = 1'b0;
      cyc(3);
      chk("post_rst_idle", int'({count, running}), 0);

      cyc(2);
      chk("ticks_outstanding", tick_exp.size(), 0);
      chk("laps_outstanding", lap_exp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
